// File: rtl/picomips_decoder_fsm_pkg.sv
// Shared picoMIPS CPU configuration: field widths, opcode/ALU encodings, controller states.
// ILLEGAL_TRAP_EN adds the HALT state used to trap undefined opcodes.
package picomips_decoder_fsm_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned O_SIZE = 4;
    localparam int unsigned R_SIZE = 4;
    localparam int unsigned A_SIZE = 2;
    localparam int unsigned I_SIZE = O_SIZE + 2*R_SIZE + N;

    localparam int unsigned OP_MSB  = I_SIZE - 1;
    localparam int unsigned RD_MSB  = OP_MSB - O_SIZE;
    localparam int unsigned RS_MSB  = RD_MSB - R_SIZE;
    localparam int unsigned IMM_MSB = RS_MSB - R_SIZE;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [O_SIZE-1:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_ADDI = 4'd3,
        OP_MUL  = 4'd4
    } opCode_t;

    typedef enum logic [A_SIZE-1:0] {
        ALU_A   = 2'd0,
        ALU_B   = 2'd1,
        ALU_ADD = 2'd2,
        ALU_MUL = 2'd3
    } aluFunc_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB
`ifdef ILLEGAL_TRAP_EN
        , HALT
`endif
    } ctrlState_t;

    typedef struct packed {
        opCode_t           op;
        logic [R_SIZE-1:0] rd;
        logic [R_SIZE-1:0] rs;
        logic [N-1:0]      imm;
    } instr_t;

    function automatic logic op_defined(input opCode_t op);
        return op inside {OP_NOP, OP_LDI, OP_ADD, OP_ADDI, OP_MUL};
    endfunction

    function automatic logic op_writes(input opCode_t op);
        return op inside {OP_LDI, OP_ADD, OP_ADDI, OP_MUL};
    endfunction

endpackage

// File: rtl/picomips_exec_counter.sv
// Loadable down-counter with zero flag; stretches the EXEC state for multi-cycle ops.
module picomips_exec_counter
    import picomips_decoder_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             nReset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && !o_zero)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/picomips_decoder_fsm.sv
// picoMIPS multi-cycle decoder/controller: FETCH/DECODE/EXEC/WB sequencing and datapath controls.
// Build option ILLEGAL_TRAP_EN: undefined opcodes halt the controller until reset.
module picomips_decoder_fsm
    import picomips_decoder_fsm_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
)(
    input  logic              clk,
    input  logic              nReset,
    input  logic [I_SIZE-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [A_SIZE-1:0] alu_func,
    output logic [R_SIZE-1:0] rd_addr,
    output logic [R_SIZE-1:0] rs_addr,
    output logic [N-1:0]      imm,
    output logic              imm_sel,
    output logic              reg_we,
    output logic              pc_inc,
    output logic              illegal
);

    ctrlState_t       r_state;
    ctrlState_t       w_next;
    instr_t           r_instr;
    logic             w_xfer;
    logic             w_defined;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;

    assign w_xfer    = instr_valid && (r_state == FETCH);
    assign w_defined = op_defined(r_instr.op);
    assign w_cnt_val = (r_instr.op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;

    picomips_exec_counter u_exec_counter (
        .clk        (clk),
        .nReset     (nReset),
        .i_load     (r_state == DECODE),
        .i_load_val (w_cnt_val),
        .i_dec      (r_state == EXEC),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            r_state <= FETCH;
        else
            r_state <= w_next;
    end

    // Fields are captured on the transfer and stay visible until the next transfer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            r_instr <= '0;
        else if (w_xfer)
            r_instr <= instr_t'(instr);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   if (w_xfer) w_next = DECODE;
            DECODE: begin
                if (!w_defined)
`ifdef ILLEGAL_TRAP_EN
                    w_next = HALT;
`else
                    w_next = WB;
`endif
                else if (r_instr.op == OP_NOP)
                    w_next = WB;
                else
                    w_next = EXEC;
            end
            EXEC:    if (w_cnt_zero) w_next = WB;
            WB:      w_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
            HALT:    w_next = HALT;
`endif
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        instr_ready = (r_state == FETCH);
        pc_inc      = (r_state == WB);
        reg_we      = (r_state == WB) && op_writes(r_instr.op);
        illegal     = (r_state == DECODE) && !w_defined;
`ifdef ILLEGAL_TRAP_EN
        illegal     = illegal || (r_state == HALT);
`endif
        alu_func    = ALU_A;
        imm_sel     = 1'b0;
        case (r_instr.op)
            OP_LDI:  begin alu_func = ALU_B;   imm_sel = 1'b1; end
            OP_ADD:  begin alu_func = ALU_ADD; imm_sel = 1'b0; end
            OP_ADDI: begin alu_func = ALU_ADD; imm_sel = 1'b1; end
            OP_MUL:  begin alu_func = ALU_MUL; imm_sel = 1'b0; end
            default: begin alu_func = ALU_A;   imm_sel = 1'b0; end
        endcase
    end

    assign rd_addr = r_instr.rd;
    assign rs_addr = r_instr.rs;
    assign imm     = r_instr.imm;

endmodule

// File: tb/tb_picomips_decoder_fsm.sv
// Bench for picomips_decoder_fsm: timing model derived from per-opcode latencies, directed + random stimulus.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_picomips_decoder_fsm;
    import picomips_decoder_fsm_pkg::*;

    localparam int MC = 3;
    localparam int NEVER = 32'h7fffffff;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic [I_SIZE-1:0] instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [A_SIZE-1:0] alu_func;
    logic [R_SIZE-1:0] rd_addr;
    logic [R_SIZE-1:0] rs_addr;
    logic [N-1:0]      imm;
    logic              imm_sel;
    logic              reg_we;
    logic              pc_inc;
    logic              illegal;

    always #5 clk = ~clk;

    picomips_decoder_fsm #(.MUL_CYCLES(MC)) u_dut (
        .clk         (clk),
        .nReset      (nReset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_func    (alu_func),
        .rd_addr     (rd_addr),
        .rs_addr     (rs_addr),
        .imm         (imm),
        .imm_sel     (imm_sel),
        .reg_we      (reg_we),
        .pc_inc      (pc_inc),
        .illegal     (illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the whole schedule of an instruction is fixed at its transfer cycle.
    int                cyc = 0;
    int                ready_at = 0;
    int                pulse_at = -1;
    bit                pulse_we = 0;
    int                ill_at = -1;
    int                halt_from = -1;
    logic [I_SIZE-1:0] old_cur = '0;
    logic [I_SIZE-1:0] new_cur = '0;
    int                cur_from = 0;

    bit                last_xfer = 0;
    logic              obs_ready, obs_isel, obs_we, obs_pc, obs_ill;
    logic [A_SIZE-1:0] obs_alu;
    logic [R_SIZE-1:0] obs_rd;
    logic [N-1:0]      obs_imm;

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0:             return 2;
            4'd1, 4'd2, 4'd3: return 3;
            4'd4:             return 2 + MC;
            default:          return 2;
        endcase
    endfunction

    function automatic bit defined_op(input logic [3:0] op);
        return op <= 4'd4;
    endfunction

    function automatic bit writes_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] op);
        case (op)
            4'd1:       return ALU_B;
            4'd2, 4'd3: return ALU_ADD;
            4'd4:       return ALU_MUL;
            default:    return ALU_A;
        endcase
    endfunction

    function automatic bit isel_of(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [I_SIZE-1:0] w);
        bit                e_halt;
        bit                e_ready;
        logic [I_SIZE-1:0] e_i;
        logic [3:0]        op;
        int                lat;
        @(negedge clk);
        e_halt  = (halt_from >= 0) && (cyc >= halt_from);
        e_ready = (cyc >= ready_at) && !e_halt;
        e_i     = (cyc >= cur_from) ? new_cur : old_cur;
        op      = e_i[19:16];
        obs_ready = instr_ready; obs_alu = alu_func; obs_rd = rd_addr; obs_imm = imm;
        obs_isel  = imm_sel; obs_we = reg_we; obs_pc = pc_inc; obs_ill = illegal;
        chk("instr_ready", instr_ready, e_ready);
        chk("alu_func", alu_func, alu_of(op));
        chk("rd_addr", rd_addr, e_i[15:12]);
        chk("rs_addr", rs_addr, e_i[11:8]);
        chk("imm", imm, e_i[7:0]);
        chk("imm_sel", imm_sel, isel_of(op));
        chk("pc_inc", pc_inc, cyc == pulse_at);
        chk("reg_we", reg_we, (cyc == pulse_at) && pulse_we);
        chk("illegal", illegal, (cyc == ill_at) || e_halt);
        nReset      = rst;
        instr_valid = v;
        instr       = w;
        last_xfer   = 0;
        if (!rst) begin
            ready_at = cyc + 1; pulse_at = -1; ill_at = -1; halt_from = -1;
            old_cur = '0; new_cur = '0; cur_from = cyc + 1;
        end else if (v && e_ready) begin
            last_xfer = 1;
            old_cur = e_i; new_cur = w; cur_from = cyc + 1;
            op = w[19:16];
            if (!defined_op(op)) begin
`ifdef ILLEGAL_TRAP_EN
                halt_from = cyc + 1; pulse_at = -1; ready_at = NEVER;
`else
                ill_at = cyc + 1; pulse_at = cyc + 2; pulse_we = 0; ready_at = cyc + 3;
`endif
            end else begin
                lat = lat_of(op);
                pulse_at = cyc + lat; pulse_we = writes_op(op); ready_at = cyc + lat + 1;
            end
        end
        cyc++;
    endtask

    // Transfer w, then idle until pc_inc; returns transfer index, latency and first illegal offset.
    task automatic issue(input logic [I_SIZE-1:0] w, output int t, output int lat, output int ill_off);
        int guard;
        t = -1; lat = -1; ill_off = -1; guard = 0;
        do begin step(1, 1, w); guard++; end while (!last_xfer && guard < 40);
        if (!last_xfer) begin chk("issue_transfer_timeout", 0, 1); return; end
        t = cyc - 1;
        guard = 0;
        do begin
            step(1, 0, '0);
            if (obs_ill && ill_off < 0) ill_off = cyc - 1 - t;
            guard++;
        end while (!obs_pc && guard < 40);
        if (!obs_pc) begin chk("issue_pulse_timeout", 0, 1); return; end
        lat = cyc - 1 - t;
    endtask

    initial begin
        int t, lat, ill_off, k, guard, cnt;
        int ts[2];
        logic [3:0] op;
        bit rst;

        // Reset held, then released
        step(0, 0, '0);
        step(0, 0, '0);
        step(1, 0, '0);
        step(1, 0, '0);
        chk("reset_ready_lit", obs_ready, 1);
        chk("reset_alu_lit", obs_alu, ALU_A);
        chk("reset_we_pc_ill_lit", {obs_we, obs_pc, obs_ill, obs_isel}, 4'b0000);

        // LDI r3, 0x5A
        issue(20'h1305A, t, lat, ill_off);
        chk("ldi_latency", lat, 3);
        chk("ldi_alu_lit", obs_alu, ALU_B);
        chk("ldi_rd_lit", obs_rd, 4'd3);
        chk("ldi_imm_lit", obs_imm, 8'h5A);
        chk("ldi_isel_we_lit", {obs_isel, obs_we}, 2'b11);
        step(1, 0, '0);
        chk("ldi_pulse_width", {obs_we, obs_pc}, 2'b00);

        // ADD then ADDI with valid held high
        k = 0; guard = 0; ts[0] = 0; ts[1] = 0;
        while (k < 2 && guard < 40) begin
            step(1, 1, (k == 0) ? 20'h21200 : 20'h310FF);
            if (last_xfer) begin ts[k] = cyc - 1; k++; end
            guard++;
        end
        chk("add_addi_transfers", k, 2);
        chk("add_addi_spacing", ts[1] - ts[0], 4);
        guard = 0;
        do begin step(1, 0, '0); guard++; end while (!obs_pc && guard < 40);
        chk("addi_alu_lit", obs_alu, ALU_ADD);
        chk("addi_imm_isel_lit", {obs_imm, obs_isel}, {8'hFF, 1'b1});

        // MUL with MC=3
        issue(20'h42500, t, lat, ill_off);
        chk("mul_latency", lat, 5);
        chk("mul_alu_we_lit", {obs_alu, obs_we}, {ALU_MUL, 1'b1});

        // NOP: pc only
        issue(20'h00000, t, lat, ill_off);
        chk("nop_latency", lat, 2);
        chk("nop_we_lit", obs_we, 0);

`ifdef ILLEGAL_TRAP_EN
        guard = 0;
        do begin step(1, 1, 20'h90000); guard++; end while (!last_xfer && guard < 40);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 20'h1305A);
            if (obs_pc || obs_we) cnt++;
        end
        chk("trap_illegal_held_lit", obs_ill, 1);
        chk("trap_ready_low_lit", obs_ready, 0);
        chk("trap_no_pulses", cnt, 0);
        step(0, 0, '0);
        step(1, 0, '0);
        step(1, 0, '0);
        chk("trap_recover_ready_lit", obs_ready, 1);
        chk("trap_recover_ill_lit", obs_ill, 0);
`else
        issue(20'h90000, t, lat, ill_off);
        chk("undef_latency", lat, 2);
        chk("undef_ill_offset", ill_off, 1);
        chk("undef_we_ill_at_pulse", {obs_we, obs_ill}, 2'b00);
`endif

        // Reset pulse during MUL EXEC
        guard = 0;
        do begin step(1, 1, 20'h47300); guard++; end while (!last_xfer && guard < 40);
        step(1, 0, '0);
        step(1, 0, '0);
        step(0, 0, '0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, '0);
            if (obs_pc || obs_we) cnt++;
        end
        chk("midmul_no_pulse", cnt, 0);
        chk("midmul_ready_lit", obs_ready, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            op = 4'($urandom_range(0, 5));
            if (op == 4'd5) op = 4'($urandom_range(5, 15));
            rst = ($urandom_range(0, 149) != 0);
            if ((halt_from >= 0) && (cyc > halt_from + 4)) rst = 0;
            step(rst, ($urandom_range(0, 3) != 0), {op, 16'($urandom)});
        end
        step(1, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
